imm_extend_pipe: RTL



---
 rtl/mips_imm_pkg.sv | 15 +
 rtl/imm_ext_core.sv | 37 +++
 rtl/imm_extend_pipe.sv | 111 +++++++++++
 3 files changed

// File: rtl/mips_imm_pkg.sv
// Shared types and default widths for the MIPS immediate-extension stage.
package mips_imm_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    // Extension mode selector carried with each decoded immediate.
    typedef enum logic [1:0] {
        SIGN   = 2'b00,
        ZERO   = 2'b01,
        UPPER  = 2'b10,
        BRANCH = 2'b11
    } imm_mode_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: sign, zero, upper (LUI) and branch-offset forms.
module imm_ext_core
    import mips_imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  imm,
    input  imm_mode_t        mode,
    output logic [OUT_W-1:0] ext
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] upper_ext;
    logic [OUT_W-1:0] branch_ext;

    assign sign_ext   = {{PAD_W{imm[IN_W-1]}}, imm};
    assign zero_ext   = {{PAD_W{1'b0}}, imm};
    assign upper_ext  = {imm, {PAD_W{1'b0}}};
    assign branch_ext = sign_ext << 2;

    // Select the extension form requested by the decoder.
    always_comb begin
        ext = sign_ext;
        case (mode)
            SIGN:    ext = sign_ext;
            ZERO:    ext = zero_ext;
            UPPER:   ext = upper_ext;
            BRANCH:  ext = branch_ext;
            default: ext = sign_ext;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extension with a main register and a one-deep skid buffer.
module imm_extend_pipe
    import mips_imm_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  imm_mode_t        in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // The branch form needs two spare bits above the immediate.
    if (OUT_W < IN_W + 2) begin : g_width_check
        $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
    end

    logic [OUT_W-1:0] ext_data;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;
    logic [TAG_W-1:0] skid_tag;

    logic             accept;
    logic             consume;

    logic             out_valid_n;
    logic [OUT_W-1:0] out_data_n;
    logic [TAG_W-1:0] out_tag_n;
    logic             skid_valid_n;
    logic [OUT_W-1:0] skid_data_n;
    logic [TAG_W-1:0] skid_tag_n;
    logic             in_ready_n;

    // Single extender ahead of both registers so held entries are already extended.
    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (ext_data)
    );

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Next-state for main and skid entries; flush wins over every other event.
    always_comb begin
        out_valid_n  = out_valid;
        out_data_n   = out_data;
        out_tag_n    = out_tag;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        skid_tag_n   = skid_tag;

        if (flush) begin
            out_valid_n  = 1'b0;
            skid_valid_n = 1'b0;
        end else if (consume && skid_valid) begin
            out_valid_n  = 1'b1;
            out_data_n   = skid_data;
            out_tag_n    = skid_tag;
            skid_valid_n = 1'b0;
        end else if (accept && (!out_valid || consume)) begin
            out_valid_n = 1'b1;
            out_data_n  = ext_data;
            out_tag_n   = in_tag;
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = ext_data;
            skid_tag_n   = in_tag;
        end else if (consume) begin
            out_valid_n = 1'b0;
        end

        in_ready_n = ~skid_valid_n;
    end

    // State registers; in_ready is its own flop so it never depends on out_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_tag   <= '0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= out_valid_n;
            out_data   <= out_data_n;
            out_tag    <= out_tag_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            skid_tag   <= skid_tag_n;
            in_ready   <= in_ready_n;
        end
    end

endmodule
